// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth multiplier controller:
// state encoding, iteration count, Booth pair codes and the output decode.
package booth_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_ADD   = 3'd3,
    S_SUB   = 3'd4,
    S_SHIFT = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  localparam int BOOTH_ITER = 16;

  // {q0, q_minus1} codes that require an ALU operation; 00/11 shift only.
  localparam logic [1:0] PAIR_ADD = 2'b01;
  localparam logic [1:0] PAIR_SUB = 2'b10;

  typedef struct packed {
    logic ldm;
    logic ldq;
    logic clra;
    logic clr_q1;
    logic ldcnt;
    logic lda;
    logic addsub;
    logic shift;
    logic decr;
    logic ready;
    logic busy;
    logic done;
  } ctl_t;

  // Pure function of the state: every strobe is a Moore output.
  function automatic ctl_t ctl_decode(input state_e s);
    ctl_t c;
    c = '0;
    unique case (s)
      S_IDLE: c.ready = 1'b1;
      S_LOAD: begin
        c.ldm    = 1'b1;
        c.ldq    = 1'b1;
        c.clra   = 1'b1;
        c.clr_q1 = 1'b1;
        c.ldcnt  = 1'b1;
        c.busy   = 1'b1;
      end
      S_CHECK: c.busy = 1'b1;
      S_ADD: begin
        c.lda    = 1'b1;
        c.addsub = 1'b1;
        c.busy   = 1'b1;
      end
      S_SUB: begin
        c.lda  = 1'b1;
        c.busy = 1'b1;
      end
      S_SHIFT: begin
        c.shift = 1'b1;
        c.decr  = 1'b1;
        c.busy  = 1'b1;
      end
      S_DONE: begin
        c.done = 1'b1;
        c.busy = 1'b1;
      end
      default: c.ready = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/booth_controller.sv
// Moore sequencer for the 16-bit radix-2 Booth multiplier datapath.
// Outputs are registered copies of the decode of the next state, so they
// depend only on the state register and have no path from any input.
// The internal shift counter cross-checks the datapath's eqz flag.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready for start
// LOAD  | load M, Q, count; clear A and history bit; clear cnt/err
// CHECK | exit test (eqz / cnt==ITER) and Booth pair decode
// ADD   | A <= A + M
// SUB   | A <= A - M
// SHIFT | arithmetic shift {A,Q,q_minus1}, decrement count, cnt+1
// DONE  | one-cycle done pulse, product valid
module booth_controller
  import booth_pkg::*;
#(
  parameter int ITER = BOOTH_ITER,
  parameter int CW   = 5            // 2**CW must exceed ITER
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  input  logic eqz,
  input  logic q0,
  input  logic q_minus1,
  output logic ldM,
  output logic ldQ,
  output logic clrA,
  output logic clr_q1,
  output logic ldcnt,
  output logic clrQ,
  output logic ldA,
  output logic addsub,
  output logic shift,
  output logic decr,
  output logic ready,
  output logic busy,
  output logic done,
  output logic err
);

  localparam logic [CW-1:0] ITER_C = CW'(ITER);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  ctl_t          ctl_q, ctl_d;
  logic          cnt_hit;

  assign cnt_hit = (cnt_q == ITER_C);

  // Next-state, shift counter and sticky error; abort freezes cnt and err.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) state_d = S_LOAD;
        end
        S_LOAD: begin
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = S_CHECK;
        end
        S_CHECK: begin
          if (eqz != cnt_hit) err_d = 1'b1;
          if (eqz || cnt_hit) begin
            state_d = S_DONE;
          end else begin
            unique case ({q0, q_minus1})
              PAIR_ADD: state_d = S_ADD;
              PAIR_SUB: state_d = S_SUB;
              default:  state_d = S_SHIFT;
            endcase
          end
        end
        S_ADD:   state_d = S_SHIFT;
        S_SUB:   state_d = S_SHIFT;
        S_SHIFT: begin
          cnt_d   = cnt_q + 1'b1;
          state_d = S_CHECK;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    ctl_d = ctl_decode(state_d);
  end

  // State, counter, error and registered output strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ctl_q   <= ctl_decode(S_IDLE);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ctl_q   <= ctl_d;
    end
  end

  assign ldM    = ctl_q.ldm;
  assign ldQ    = ctl_q.ldq;
  assign clrA   = ctl_q.clra;
  assign clr_q1 = ctl_q.clr_q1;
  assign ldcnt  = ctl_q.ldcnt;
  assign clrQ   = 1'b0;
  assign ldA    = ctl_q.lda;
  assign addsub = ctl_q.addsub;
  assign shift  = ctl_q.shift;
  assign decr   = ctl_q.decr;
  assign ready  = ctl_q.ready;
  assign busy   = ctl_q.busy;
  assign done   = ctl_q.done;
  assign err    = err_q;

endmodule

// File: tb/tb_booth_controller.sv
// Bench for booth_controller: a behavioural datapath reacts to the strobes,
// and results are compared against signed multiplication and a Booth
// transition count computed directly from the operands.
module tb_booth_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic eqz, q0, q_minus1;
  logic ldM, ldQ, clrA, clr_q1, ldcnt, clrQ, ldA, addsub, shift, decr;
  logic ready, busy, done, err;

  logic        eqz_force = 1'b0;
  logic [15:0] m_in = '0;
  logic [15:0] q_in = '0;
  logic [15:0] dp_m, dp_a, dp_q;
  logic        dp_q1;
  logic [4:0]  dp_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  booth_controller dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .eqz(eqz), .q0(q0), .q_minus1(q_minus1),
    .ldM(ldM), .ldQ(ldQ), .clrA(clrA), .clr_q1(clr_q1), .ldcnt(ldcnt),
    .clrQ(clrQ), .ldA(ldA), .addsub(addsub), .shift(shift), .decr(decr),
    .ready(ready), .busy(busy), .done(done), .err(err)
  );

  assign eqz      = (dp_cnt == 5'd0) | eqz_force;
  assign q0       = dp_q[0];
  assign q_minus1 = dp_q1;

  // Behavioural datapath driven by the controller strobes.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_m <= '0; dp_a <= '0; dp_q <= '0; dp_q1 <= 1'b0; dp_cnt <= '0;
    end else begin
      if (ldM)    dp_m   <= m_in;
      if (ldQ)    dp_q   <= q_in;
      if (clrA)   dp_a   <= '0;
      if (clr_q1) dp_q1  <= 1'b0;
      if (ldcnt)  dp_cnt <= 5'd16;
      if (ldA)    dp_a   <= addsub ? dp_a + dp_m : dp_a - dp_m;
      if (shift) begin
        dp_a  <= {dp_a[15], dp_a[15:1]};
        dp_q  <= {dp_a[0], dp_q[15:1]};
        dp_q1 <= dp_q[0];
      end
      if (decr)   dp_cnt <= dp_cnt - 5'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe invariants on every active cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("inv_lda_shift", {31'd0, ldA & shift}, 32'd0);
      chk("inv_decr_shift", {31'd0, decr & ~shift}, 32'd0);
      chk("inv_addsub", {31'd0, addsub & ~ldA}, 32'd0);
      chk("inv_clrq", {31'd0, clrQ}, 32'd0);
    end
  end

  function automatic int booth_k(input logic [15:0] q);
    logic [15:0] prev;
    prev = {q[14:0], 1'b0};
    return $countones(q ^ prev);
  endfunction

  function automatic logic [31:0] ref_prod(input logic [15:0] m, input logic [15:0] q);
    logic signed [31:0] ms, qs;
    ms = $signed({{16{m[15]}}, m});
    qs = $signed({{16{q[15]}}, q});
    return ms * qs;
  endfunction

  // One multiply from start to the cycle after done.
  task automatic do_mul(input logic [15:0] m, input logic [15:0] q,
                        input bit hold_start, input bit abort_too);
    int cyc, done_cyc, nlda, loads, k;
    logic err_c2;
    m_in = m;
    q_in = q;
    k = booth_k(q);
    @(negedge clk);
    chk("ready_before", {31'd0, ready}, 32'd1);
    start = 1'b1;
    abort = abort_too;
    @(posedge clk);
    #1;
    cyc = 1;
    abort = 1'b0;
    if (!hold_start) start = 1'b0;
    chk("load_strobes", {25'd0, ldM, ldQ, clrA, clr_q1, ldcnt, busy, ready}, 32'b1111110);
    done_cyc = 0; nlda = 0; loads = 0; err_c2 = 1'bx;
    while (done_cyc == 0 && cyc < 80) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 2) err_c2 = err;
      if (ldA) nlda++;
      if (ldM) loads++;
      if (done) begin
        done_cyc = cyc;
        start = 1'b0;
      end
    end
    chk("done_seen", {31'd0, done_cyc != 0}, 32'd1);
    chk("done_cycle", done_cyc, 35 + k);
    chk("product", {dp_a, dp_q}, ref_prod(m, q));
    chk("alu_ops", nlda, k);
    chk("err_cleared", {31'd0, err_c2}, 32'd0);
    chk("err_at_done", {31'd0, err}, 32'd0);
    if (hold_start) chk("start_ignored", loads, 0);
    @(posedge clk);
    #1;
    chk("idle_after", {29'd0, ready, busy, done}, 32'b100);
  endtask

  initial begin
    int cyc, nchk;
    logic [15:0] rm, rq;
    bit seen_done;

    // Reset state
    #12;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_outs", {19'd0, ldM, ldQ, clrA, clr_q1, ldcnt, clrQ, ldA, addsub,
                     shift, decr, busy, done, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed multiplies
    do_mul(16'd5, 16'd3, 1'b0, 1'b0);
    do_mul(16'hFFF9, 16'd3, 1'b0, 1'b0);
    do_mul(16'h1234, 16'h0000, 1'b0, 1'b0);
    do_mul(16'd1, 16'h5555, 1'b0, 1'b0);

    // Abort in IDLE does nothing
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_idle", {30'd0, ready, busy}, 32'b10);

    // Abort during cycle 10 -> IDLE at cycle 11, no done
    m_in = 16'd7; q_in = 16'd9;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 1;
    seen_done = 1'b0;
    while (cyc < 10) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) seen_done = 1'b1;
    end
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_idle_next", {29'd0, ready, busy, done}, 32'b100);
    chk("abort_no_done", {31'd0, seen_done}, 32'd0);
    do_mul(16'd2, 16'd2, 1'b0, 1'b0);

    // Simultaneous start and abort in IDLE: start wins
    do_mul(16'd11, 16'hFF00, 1'b0, 1'b1);

    // Asynchronous reset mid-operation
    m_in = 16'd9; q_in = 16'h00AA;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    start = 1'b0;
    repeat (8) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_ready", {31'd0, ready}, 32'd1);
    chk("arst_outs", {19'd0, ldM, ldQ, clrA, clr_q1, ldcnt, clrQ, ldA, addsub,
                      shift, decr, busy, done, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Force eqz at the 5th CHECK -> early DONE with sticky err
    m_in = 16'd3; q_in = 16'h00F0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    nchk = 0;
    cyc = 1;
    while (nchk < 5 && cyc < 80) begin
      @(posedge clk);
      #1;
      cyc++;
      if (busy && !done && !ldM && !ldA && !shift) nchk++;
    end
    chk("fifth_check_seen", nchk, 5);
    eqz_force = 1'b1;
    @(posedge clk);
    #1;
    eqz_force = 1'b0;
    chk("forced_done", {31'd0, done}, 32'd1);
    chk("forced_err", {31'd0, err}, 32'd1);
    @(posedge clk);
    #1;
    chk("err_sticky_idle", {30'd0, ready, err}, 32'b11);
    repeat (3) @(posedge clk);
    #1;
    chk("err_sticky_hold", {31'd0, err}, 32'd1);

    // Next LOAD clears err; start held high through busy is ignored
    do_mul(16'd13, 16'h0F0F, 1'b1, 1'b0);

    // Randomized multiplies
    for (int i = 0; i < 8; i++) begin
      rm = 16'($urandom);
      rq = 16'($urandom);
      do_mul(rm, rq, bit'($urandom_range(0, 1)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
